// File: rtl/activation_if.sv
// Bundle of config, beat and counter signals for the activation stage.
// master drives beats and config; slave is the activation pipeline.
interface activation_if #(
  parameter int NUM_WIDTH   = 16,
  parameter int CHANNELS    = 4,
  parameter int SHIFT_WIDTH = 4,
  parameter int CNT_WIDTH   = 32
);
  logic                            cfg_valid;
  logic [1:0]                      cfg_mode;
  logic [SHIFT_WIDTH-1:0]          cfg_shift;
  logic [NUM_WIDTH-1:0]            cfg_clamp;
  logic                            up_valid;
  logic [CHANNELS*NUM_WIDTH-1:0]   up_data;
  logic                            dn_valid;
  logic [CHANNELS*NUM_WIDTH-1:0]   dn_data;
  logic                            cnt_clear;
  logic [CNT_WIDTH-1:0]            zero_count;

  modport master (
    output cfg_valid, cfg_mode, cfg_shift,
    output cfg_clamp, up_valid, up_data,
    output cnt_clear,
    input  dn_valid, dn_data, zero_count
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_shift,
    input  cfg_clamp, up_valid, up_data,
    input  cnt_clear,
    output dn_valid, dn_data, zero_count
  );
endinterface

// File: rtl/activation.sv
// Multi-lane bypass/relu/leaky/clip activation, 2-stage pipeline,
// with a saturating count of lanes forced to zero.
module activation #(
  parameter int NUM_WIDTH   = 16,
  parameter int CHANNELS    = 4,
  parameter int SHIFT_WIDTH = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic        clk,
  input  logic        rst,
  activation_if.slave bus
);
  localparam int DW = NUM_WIDTH * CHANNELS;
  localparam int CW = $clog2(CHANNELS + 1);

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_RELU   = 2'd1,
    MODE_LEAKY  = 2'd2,
    MODE_CLIP   = 2'd3
  } mode_e;

  mode_e                        mode_q, mode_d;
  logic [SHIFT_WIDTH-1:0]       shift_q, shift_d;
  logic signed [NUM_WIDTH-1:0]  clamp_q, clamp_d;

  logic                         s1_valid_q, s1_valid_d;
  logic [DW-1:0]                s1_data_q, s1_data_d;
  logic                         dn_valid_q, dn_valid_d;
  logic [DW-1:0]                dn_data_q, dn_data_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;

  logic [DW-1:0]                act;
  logic [CW-1:0]                neg_cnt;
  logic signed [NUM_WIDTH-1:0]  x;
  logic signed [NUM_WIDTH-1:0]  y;
  logic                         neg;
  logic                         count_en;
  logic [CNT_WIDTH:0]           cnt_sum;

  always_comb begin
    mode_d  = mode_q;
    shift_d = shift_q;
    clamp_d = clamp_q;
    if (bus.cfg_valid) begin
      mode_d  = mode_e'(bus.cfg_mode);
      shift_d = bus.cfg_shift;
      clamp_d = bus.cfg_clamp;
    end
  end

  always_comb begin
    act     = '0;
    neg_cnt = '0;
    x       = '0;
    y       = '0;
    neg     = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      x   = bus.up_data[i*NUM_WIDTH +: NUM_WIDTH];
      neg = x[NUM_WIDTH-1];
      unique case (mode_q)
        MODE_BYPASS: y = x;
        MODE_RELU:   y = neg ? '0 : x;
        MODE_LEAKY:  y = neg ? (x >>> shift_q) : x;
        MODE_CLIP: begin
          if (neg)              y = '0;
          else if (x > clamp_q) y = clamp_q;
          else                  y = x;
        end
        default:     y = x;
      endcase
      act[i*NUM_WIDTH +: NUM_WIDTH] = y;
      neg_cnt = neg_cnt + CW'(neg);
    end
  end

  // Sign bit alone decides what counts as zeroed.
  always_comb begin
    count_en = bus.up_valid &&
               (mode_q == MODE_RELU || mode_q == MODE_CLIP);
    cnt_sum  = {1'b0, cnt_q};
    if (count_en)
      cnt_sum = cnt_sum + (CNT_WIDTH+1)'(neg_cnt);
    if (bus.cnt_clear)
      cnt_d = '0;
    else if (cnt_sum[CNT_WIDTH])
      cnt_d = '1;
    else
      cnt_d = cnt_sum[CNT_WIDTH-1:0];
  end

  always_comb begin
    s1_valid_d = bus.up_valid;
    s1_data_d  = bus.up_valid ? act : s1_data_q;
    dn_valid_d = s1_valid_q;
    dn_data_d  = s1_valid_q ? s1_data_q : dn_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_RELU;
      shift_q    <= '0;
      clamp_q    <= {1'b0, {(NUM_WIDTH-1){1'b1}}};
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      dn_valid_q <= 1'b0;
      dn_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      mode_q     <= mode_d;
      shift_q    <= shift_d;
      clamp_q    <= clamp_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      dn_valid_q <= dn_valid_d;
      dn_data_q  <= dn_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.dn_valid   = dn_valid_q;
  assign bus.dn_data    = dn_data_q;
  assign bus.zero_count = cnt_q;
endmodule

// File: doc/activation.md
# activation

Multi-channel, mode-selectable activation stage for the convolution output path. Applies bypass, ReLU, leaky ReLU (power-of-two slope) or clipped ReLU to CHANNELS signed lanes in parallel, with a registered configuration and a valid-qualified 2-cycle pipeline. Keeps a saturating count of lanes forced to zero, used for sparsity statistics. It sits between the accumulator/bias stage and the pooling/write-back path. It generalises the single-lane bypass/ReLU unit.

## Interface
- NUM_WIDTH, 16, lane width, two's complement
- CHANNELS, 4, lanes processed per beat
- SHIFT_WIDTH, 4, width of leaky-ReLU shift amount
- CNT_WIDTH, 32, width of zero counter
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_valid  in  1  load cfg_* into active configuration this cycle
- cfg_mode  in  2  0 bypass, 1 relu, 2 leaky, 3 clip
- cfg_shift  in  SHIFT_WIDTH  leaky slope = 2^-cfg_shift
- cfg_clamp  in  NUM_WIDTH  clip ceiling, signed, must be >= 0
- up_valid  in  1  up_data holds a beat
- up_data  in  CHANNELS*NUM_WIDTH  lane i at [i*NUM_WIDTH +: NUM_WIDTH]
- dn_valid  out  1  dn_data holds a result beat
- dn_data  out  CHANNELS*NUM_WIDTH  activated lanes, same packing
- cnt_clear  in  1  zero the counter
- zero_count  out  CNT_WIDTH  saturating count of lanes zeroed

## Operation
- Active config registers: mode, shift, clamp. Reset values: mode=1 (relu), shift=0, clamp=2^(NUM_WIDTH-1)-1. On cfg_valid the registers load at the next edge.
- Per lane x, where neg = x[NUM_WIDTH-1]:
  - bypass: y = x.
  - relu: y = neg ? 0 : x.
  - leaky: y = neg ? (x >>> shift) : x. The shift is arithmetic and rounds toward −inf, so −1 stays −1 for any shift. shift=0 passes x.
  - clip: y = neg ? 0 : (x > clamp ? clamp : x), using a signed compare. A negative clamp is outside the contract; the output is then undefined.
- Lanes are independent. There is no cross-lane arithmetic and no width growth; the output lane is NUM_WIDTH bits.
- There is no backpressure. A beat is accepted on every cycle where up_valid=1.
- Zero counter:
  - Each accepted beat in relu or clip mode adds the number of lanes with neg=1 (0..CHANNELS). Bypass and leaky modes add 0. Positive lanes clipped to a clamp of 0 are not counted; the sign bit alone decides.
  - The counter saturates at 2^CNT_WIDTH−1 and holds there.
  - cnt_clear has priority. If it coincides with an increment, the result is 0 and that beat's increment is lost.

## Timing
- Latency is 2 cycles. A beat with up_valid at edge t appears with dn_valid=1 after edge t+2.
  - Stage 1 registers the computed lanes and the valid bit.
  - Stage 2 registers dn_data and dn_valid.
- The valid bits in both stages reset to 0 on rst. Data registers load only when their stage valid is 1; otherwise they hold.
- Reset values: dn_valid=0, dn_data=0, zero_count=0, plus the config values above.
- Config timing: a beat presented in the same cycle as cfg_valid uses the old config. A beat presented in the next cycle uses the new config. Beats already in the pipeline are unaffected, so back-to-back beats may use different modes.
- zero_count updates at the edge where the beat enters stage 1, one cycle before its dn_valid.
- Reset mid-operation: in-flight beats are discarded and dn_valid is 0 on the cycle after the rst edge. A beat presented while rst=1 is dropped. Full throughput resumes on the first cycle with rst=0.
- Continuous up_valid yields continuous dn_valid with no bubbles.

## Test plan
- Reset defaults, NUM_WIDTH=16, CHANNELS=4: up_data lanes {0x8000, 0xFFFF, 0x0000, 0x7FFF}, valid at t → at t+2 dn_data {0, 0, 0, 0x7FFF}, dn_valid=1, zero_count=2.
- Leaky with shift=2: lanes {−8, −1, −3, 12} → {−2, −1, −1, 12}. Repeat with shift=0 → the input is unchanged. zero_count does not change.
- Clip with clamp=100: lanes {101, 100, −5, 0x7FFF} → {100, 100, 0, 100}, zero_count +1. Repeat with clamp=0: lanes {5, −5, 0, 1} → {0, 0, 0, 0}, zero_count +1.
- Config boundary: stream continuous beats of {−4, −4, −4, −4} and assert cfg_valid to bypass in the cycle of beat k. Beat k outputs zeros. Beat k+1 outputs −4 in all lanes. dn_valid stays high with no gaps.
- Counter:
  - Preload to 2^32−3, then present 2 beats of all-negative lanes → zero_count=2^32−1 and holds.
  - cnt_clear coincident with an all-negative beat → zero_count=0.
- Mid-stream rst: with 3 beats in flight, assert rst for 1 cycle → dn_valid=0 on the following cycle and the pending beats never appear. Config and counter return to their reset values.
